control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 154 +++++++++++++++
 tb/tb_control_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle instruction decode/sequencing FSM driving ALU, register file and immediate bus
// Optional retired-instruction counter is built only with CONTROL_UNIT_RETIRE_COUNT_EN defined.
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [2:0]  alu_function_sel,
    output logic        alu_store_1,
    output logic        alu_store_2,
    output logic        alu_broadcast,
    output logic [4:0]  register_index,
    output logic        register_read_enable,
    output logic        register_write_enable,
    output logic [31:0] imm,
    output logic        imm_EN,
    output logic        illegal_op,
    output logic [15:0] retired_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_OP_A   = 3'd1;
    localparam logic [2:0] S_OP_B   = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_WB_IMM = 3'd4;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_LDI  = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_MOV  = 4'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [31:0] r_ir;
    logic        r_illegal;
    logic        w_accept;
    logic [3:0]  w_in_op;
    logic [3:0]  w_ir_op;
    logic [31:0] w_ir_sext;

    assign w_in_op   = instr[31:28];
    assign w_ir_op   = r_ir[31:28];
    assign w_ir_sext = {{14{r_ir[17]}}, r_ir[17:0]};

    // Ready is masked by reset so nothing is offered while the async reset is held.
    assign instr_ready = (r_state == S_IDLE) && !reset;
    assign w_accept    = instr_valid && instr_ready;
    assign illegal_op  = r_illegal;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (w_in_op)
                        OP_ADD, OP_SUB, OP_ADDI, OP_MOV: w_next_state = S_OP_A;
                        OP_LDI:                          w_next_state = S_WB_IMM;
                        default:                         w_next_state = S_IDLE;
                    endcase
                end
            end
            S_OP_A:   w_next_state = S_OP_B;
            S_OP_B:   w_next_state = S_WB;
            S_WB:     w_next_state = S_IDLE;
            S_WB_IMM: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_illegal <= w_accept && (w_in_op > OP_MOV);
            if (w_accept) begin
                r_ir <= instr;
            end
        end
    end

    // Moore decode: every control is a function of state and IR only.
    always_comb begin
        alu_function_sel      = 3'd0;
        alu_store_1           = 1'b0;
        alu_store_2           = 1'b0;
        alu_broadcast         = 1'b0;
        register_index        = 5'd0;
        register_read_enable  = 1'b0;
        register_write_enable = 1'b0;
        imm                   = 32'd0;
        imm_EN                = 1'b0;
        case (r_state)
            S_OP_A: begin
                register_index       = r_ir[22:18];
                register_read_enable = 1'b1;
                alu_store_1          = 1'b1;
            end
            S_OP_B: begin
                alu_store_2 = 1'b1;
                if ((w_ir_op == OP_ADD) || (w_ir_op == OP_SUB)) begin
                    register_index       = r_ir[17:13];
                    register_read_enable = 1'b1;
                end else begin
                    // MOV is rd = rs1 + 0, so the second operand is a zero immediate.
                    imm_EN = 1'b1;
                    imm    = (w_ir_op == OP_ADDI) ? w_ir_sext : 32'd0;
                end
            end
            S_WB: begin
                alu_broadcast         = 1'b1;
                register_index        = r_ir[27:23];
                register_write_enable = 1'b1;
                alu_function_sel      = (w_ir_op == OP_SUB) ? 3'd2 : 3'd1;
            end
            S_WB_IMM: begin
                imm_EN                = 1'b1;
                imm                   = w_ir_sext;
                register_index        = r_ir[27:23];
                register_write_enable = 1'b1;
            end
            default: begin
                alu_function_sel = 3'd0;
            end
        endcase
    end

`ifdef CONTROL_UNIT_RETIRE_COUNT_EN
    logic [15:0] r_retired;
    logic        w_retire;

    // WB and WB_IMM always last one cycle, so being in them means leaving on this edge.
    assign w_retire = (r_state == S_WB) || (r_state == S_WB_IMM) ||
                      (w_accept && (w_in_op == OP_NOP));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= 16'd0;
        end else if (w_retire) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign retired_count = r_retired;
`else
    assign retired_count = 16'd0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit with a cycle-budget reference model
// Counter checks follow CONTROL_UNIT_RETIRE_COUNT_EN when defined.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  alu_function_sel;
    logic        alu_store_1;
    logic        alu_store_2;
    logic        alu_broadcast;
    logic [4:0]  register_index;
    logic        register_read_enable;
    logic        register_write_enable;
    logic [31:0] imm;
    logic        imm_EN;
    logic        illegal_op;
    logic [15:0] retired_count;

    control_unit dut (
        .clk                   (clk),
        .reset                 (reset),
        .instr                 (instr),
        .instr_valid           (instr_valid),
        .instr_ready           (instr_ready),
        .alu_function_sel      (alu_function_sel),
        .alu_store_1           (alu_store_1),
        .alu_store_2           (alu_store_2),
        .alu_broadcast         (alu_broadcast),
        .register_index        (register_index),
        .register_read_enable  (register_read_enable),
        .register_write_enable (register_write_enable),
        .imm                   (imm),
        .imm_EN                (imm_EN),
        .illegal_op            (illegal_op),
        .retired_count         (retired_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready;
        logic        chk_idx;
        logic [4:0]  idx;
        logic        rd_en;
        logic        wr_en;
        logic        st1;
        logic        st2;
        logic        bc;
        logic        imm_en;
        logic        chk_imm;
        logic [31:0] imm;
        logic        chk_sel;
        logic [2:0]  sel;
        logic        ill;
        logic [15:0] ret;
    } rec_t;

    rec_t        exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          busy  = 0;
    logic [15:0] model_ret = 16'd0;
    rec_t        mon_e;
    logic        mon_ok;

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [17:0] i18);
        logic [31:0] w;
        w = {op, rd, rs1, i18};
        w[17:13] = (op == 4'd3 || op == 4'd4) ? i18[17:13] : rs2;
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic retire_one();
`ifdef CONTROL_UNIT_RETIRE_COUNT_EN
        model_ret = model_ret + 16'd1;
`endif
    endtask

    // Reference model: an accepted instruction maps to a list of expected busy cycles.
    task automatic accept(input logic [31:0] w);
        rec_t r;
        logic [3:0]  op;
        logic [31:0] sx;
        op = w[31:28];
        sx = {{14{w[17]}}, w[17:0]};
        r = '0;
        r.ret = model_ret;
        if (op == 4'd1 || op == 4'd2 || op == 4'd4 || op == 4'd5) begin
            r.chk_idx = 1'b1; r.idx = w[22:18]; r.rd_en = 1'b1; r.st1 = 1'b1;
            exp_q.push_back(r);
            r = '0; r.ret = model_ret; r.st2 = 1'b1;
            if (op == 4'd1 || op == 4'd2) begin
                r.chk_idx = 1'b1; r.idx = w[17:13]; r.rd_en = 1'b1;
            end else begin
                r.imm_en = 1'b1; r.chk_imm = 1'b1; r.imm = (op == 4'd4) ? sx : 32'd0;
            end
            exp_q.push_back(r);
            r = '0; r.ret = model_ret;
            r.chk_idx = 1'b1; r.idx = w[27:23]; r.wr_en = 1'b1; r.bc = 1'b1;
            r.chk_sel = 1'b1; r.sel = (op == 4'd2) ? 3'd2 : 3'd1;
            exp_q.push_back(r);
            busy = 3;
        end else if (op == 4'd3) begin
            r.imm_en = 1'b1; r.chk_imm = 1'b1; r.imm = sx;
            r.chk_idx = 1'b1; r.idx = w[27:23]; r.wr_en = 1'b1;
            exp_q.push_back(r);
            busy = 1;
        end else if (op == 4'd0) begin
            retire_one();
        end else begin
            r.ready = 1'b1; r.ill = 1'b1; r.chk_sel = 1'b1; r.chk_imm = 1'b1;
            exp_q.push_back(r);
        end
    endtask

    // Drive one cycle of stimulus, then advance the model across the clock edge.
    task automatic cycle(input logic [31:0] w, input logic v);
        instr = w;
        instr_valid = v;
        @(posedge clk);
        if (busy > 0) begin
            busy--;
            if (busy == 0) retire_one();
        end else if (v) begin
            accept(w);
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            n_vec++;
            if ($countones({register_read_enable, alu_broadcast, imm_EN}) > 1) begin
                n_bad++;
                $display("FAIL mutex: rd_en=%b bc=%b imm_en=%b", register_read_enable, alu_broadcast, imm_EN);
            end
            if (register_read_enable || register_write_enable || alu_store_1 || alu_store_2 ||
                alu_broadcast || imm_EN || illegal_op || (alu_function_sel != 3'd0) ||
                (imm != 32'd0) || !instr_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_activity t=%0t: rdy=%b re=%b we=%b ie=%b bc=%b ill=%b, expected idle",
                             $time, instr_ready, register_read_enable, register_write_enable, imm_EN, alu_broadcast, illegal_op);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_ok = (instr_ready === mon_e.ready) && (register_read_enable === mon_e.rd_en) &&
                             (register_write_enable === mon_e.wr_en) && (alu_store_1 === mon_e.st1) &&
                             (alu_store_2 === mon_e.st2) && (alu_broadcast === mon_e.bc) &&
                             (imm_EN === mon_e.imm_en) && (illegal_op === mon_e.ill) &&
                             (retired_count === mon_e.ret) &&
                             (!mon_e.chk_idx || register_index === mon_e.idx) &&
                             (!mon_e.chk_imm || imm === mon_e.imm) &&
                             (!mon_e.chk_sel || alu_function_sel === mon_e.sel);
                    if (!mon_ok) begin
                        n_bad++;
                        $display("FAIL scoreboard t=%0t got rdy=%b idx=%0d re=%b we=%b s1=%b s2=%b bc=%b ie=%b imm=%h sel=%0d ill=%b cnt=%h expected rdy=%b idx=%0d re=%b we=%b s1=%b s2=%b bc=%b ie=%b imm=%h sel=%0d ill=%b cnt=%h",
                                 $time, instr_ready, register_index, register_read_enable, register_write_enable,
                                 alu_store_1, alu_store_2, alu_broadcast, imm_EN, imm, alu_function_sel, illegal_op, retired_count,
                                 mon_e.ready, mon_e.idx, mon_e.rd_en, mon_e.wr_en, mon_e.st1, mon_e.st2, mon_e.bc,
                                 mon_e.imm_en, mon_e.imm, mon_e.sel, mon_e.ill, mon_e.ret);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] w;
        logic [3:0]  op;
        reset = 1'b1;
        instr = 32'd0;
        instr_valid = 1'b0;
        #1;
        check("reset_ready", {31'd0, instr_ready}, 32'd0);
        check("reset_ctrl", {register_read_enable, register_write_enable, imm_EN, alu_broadcast,
                             illegal_op, alu_store_1, alu_store_2, alu_function_sel}, 32'd0);
        check("reset_count", {16'd0, retired_count}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check("ready_after_reset", {31'd0, instr_ready}, 32'd1);

        cycle(mk(4'd3, 5'd3, 5'd0, 5'd0, 18'h3FFFF), 1'b1);
        cycle(32'd0, 1'b0);
        cycle(32'd0, 1'b0);
        cycle(mk(4'd1, 5'd5, 5'd1, 5'd2, 18'd0), 1'b1);
        repeat (5) cycle(32'd0, 1'b0);
        cycle(mk(4'd15, 5'd7, 5'd7, 5'd7, 18'h1234), 1'b1);
        repeat (2) cycle(32'd0, 1'b0);

        cycle(mk(4'd4, 5'd9, 5'd4, 5'd0, 18'h20001), 1'b1);
        repeat (4) cycle(mk(4'd5, 5'd10, 5'd9, 5'd0, 18'd0), 1'b1);
        repeat (4) cycle(32'd0, 1'b0);

        cycle(mk(4'd2, 5'd6, 5'd6, 5'd8, 18'd0), 1'b1);
        cycle(32'd0, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("reset_in_opb_ctrl", {register_read_enable, register_write_enable, imm_EN, alu_broadcast,
                                    illegal_op, alu_store_1, alu_store_2, alu_function_sel, register_index}, 32'd0);
        check("reset_in_opb_ready", {31'd0, instr_ready}, 32'd0);
        exp_q.delete();
        busy = 0;
        model_ret = 16'd0;
        repeat (3) begin
            @(negedge clk);
            check("reset_no_write", {31'd0, register_write_enable}, 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check("idle_after_reset", {31'd0, instr_ready}, 32'd1);
        check("count_after_reset", {16'd0, retired_count}, 32'd0);

`ifdef CONTROL_UNIT_RETIRE_COUNT_EN
        repeat (65535) cycle(32'd0, 1'b1);
        check("count_preload", {16'd0, retired_count}, 32'h0000FFFF);
        cycle(mk(4'd3, 5'd1, 5'd0, 5'd0, 18'h00005), 1'b1);
        cycle(32'd0, 1'b0);
        check("count_wrap", {16'd0, retired_count}, 32'h00000000);
`endif

        for (int i = 0; i < 600; i++) begin
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
            w = $urandom;
            w[31:28] = op;
            cycle(w, $urandom_range(0, 3) != 0);
        end
        repeat (6) cycle(32'd0, 1'b0);
        check("queue_drained", exp_q.size(), 32'd0);
        check("final_count", {16'd0, retired_count}, {16'd0, model_ret});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
